// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-timed game sequencer owning level, per-player lives,
// invulnerability windows, level-up pause and game-over for N players.
// Optional build macro GAME_FLOW_PAUSE_EN adds pause_req/paused and a PAUSED
// state (reported as state=0 with freeze=1).
module game_flow_ctrl #(
    parameter int unsigned N_PLAYERS     = 2,
    parameter int unsigned LEVEL_W       = 4,
    parameter int unsigned MAX_LEVEL     = 9,
    parameter int unsigned LIVES_W       = 3,
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned PAUSE_FRAMES  = 120
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic                           vsync_in,
    input  logic                           start,
    input  logic [N_PLAYERS-1:0]           hit,
    input  logic                           enemies_cleared,
`ifdef GAME_FLOW_PAUSE_EN
    input  logic                           pause_req,
    output logic                           paused,
`endif
    output logic [LEVEL_W-1:0]             level,
    output logic                           level_change,
    output logic [N_PLAYERS*LIVES_W-1:0]   lives,
    output logic [N_PLAYERS-1:0]           alive,
    output logic [N_PLAYERS-1:0]           invuln,
    output logic                           freeze,
    output logic                           game_over,
    output logic [1:0]                     state
);

    localparam int unsigned FRAME_MAX = (INVULN_FRAMES > PAUSE_FRAMES) ? INVULN_FRAMES : PAUSE_FRAMES;
    localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);

    localparam logic [N_PLAYERS-1:0][LIVES_W-1:0] LIVES_RST = {N_PLAYERS{LIVES_W'(LIVES_INIT)}};
    localparam logic [N_PLAYERS-1:0]              ALIVE_RST = (LIVES_INIT != 0) ? '1 : '0;

`ifdef GAME_FLOW_PAUSE_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_LEVEL_UP  = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_PAUSED    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_LEVEL_UP  = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;
`endif

    state_t                              r_state, w_state_nx;
    logic                                r_vsync_q;
    logic                                w_tick;
    logic [LEVEL_W-1:0]                  r_level, w_level_nx;
    logic                                r_level_change, w_level_change_nx;
    logic [N_PLAYERS-1:0][LIVES_W-1:0]   r_lives, w_lives_nx;
    logic [N_PLAYERS-1:0][FRAME_W-1:0]   r_inv_cnt, w_inv_cnt_nx;
    logic [FRAME_W-1:0]                  r_pause_cnt, w_pause_cnt_nx;
    logic [N_PLAYERS-1:0]                r_alive, w_alive_nx;
    logic [N_PLAYERS-1:0]                r_invuln, w_invuln_nx;
    logic                                r_freeze, w_freeze_nx;
    logic                                r_game_over, w_game_over_nx;
    logic [1:0]                          r_state_code, w_state_code_nx;
`ifdef GAME_FLOW_PAUSE_EN
    logic                                r_paused, w_paused_nx;
`endif

    // Frame tick: one-cycle pulse on each vsync rising edge
    assign w_tick = vsync_in & ~r_vsync_q;

    // State register and all registered outputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_vsync_q      <= 1'b0;
            r_level        <= LEVEL_W'(1);
            r_level_change <= 1'b0;
            r_lives        <= LIVES_RST;
            r_inv_cnt      <= '0;
            r_pause_cnt    <= '0;
            r_alive        <= ALIVE_RST;
            r_invuln       <= '0;
            r_freeze       <= 1'b1;
            r_game_over    <= 1'b0;
            r_state_code   <= 2'd0;
`ifdef GAME_FLOW_PAUSE_EN
            r_paused       <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nx;
            r_vsync_q      <= vsync_in;
            r_level        <= w_level_nx;
            r_level_change <= w_level_change_nx;
            r_lives        <= w_lives_nx;
            r_inv_cnt      <= w_inv_cnt_nx;
            r_pause_cnt    <= w_pause_cnt_nx;
            r_alive        <= w_alive_nx;
            r_invuln       <= w_invuln_nx;
            r_freeze       <= w_freeze_nx;
            r_game_over    <= w_game_over_nx;
            r_state_code   <= w_state_code_nx;
`ifdef GAME_FLOW_PAUSE_EN
            r_paused       <= w_paused_nx;
`endif
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        w_state_nx        = r_state;
        w_level_nx        = r_level;
        w_level_change_nx = 1'b0;
        w_lives_nx        = r_lives;
        w_inv_cnt_nx      = r_inv_cnt;
        w_pause_cnt_nx    = r_pause_cnt;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx        = ST_PLAY;
                    w_level_nx        = LEVEL_W'(1);
                    w_level_change_nx = 1'b1;
                    w_lives_nx        = LIVES_RST;
                end
            end
            ST_PLAY: begin
                // Hit gating uses the registered invuln flag, so a held hit costs one life
                for (int unsigned i = 0; i < N_PLAYERS; i++) begin
                    if (w_tick && (r_inv_cnt[i] != '0)) begin
                        w_inv_cnt_nx[i] = r_inv_cnt[i] - FRAME_W'(1);
                    end
                    if (hit[i] && (r_lives[i] != '0) && !r_invuln[i]) begin
                        w_lives_nx[i]   = r_lives[i] - LIVES_W'(1);
                        w_inv_cnt_nx[i] = FRAME_W'(INVULN_FRAMES);
                    end
                end
                if (w_lives_nx == '0) begin
                    w_state_nx = ST_GAME_OVER;
                end else if (enemies_cleared) begin
                    w_state_nx        = ST_LEVEL_UP;
                    w_level_nx        = (r_level == LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(1)
                                                                         : r_level + LEVEL_W'(1);
                    w_level_change_nx = 1'b1;
                    w_pause_cnt_nx    = FRAME_W'(PAUSE_FRAMES);
                end
`ifdef GAME_FLOW_PAUSE_EN
                else if (pause_req) begin
                    w_state_nx = ST_PAUSED;
                end
`endif
            end
            ST_LEVEL_UP: begin
                for (int unsigned i = 0; i < N_PLAYERS; i++) begin
                    if (w_tick && (r_inv_cnt[i] != '0)) begin
                        w_inv_cnt_nx[i] = r_inv_cnt[i] - FRAME_W'(1);
                    end
                end
                if (w_tick && (r_pause_cnt != '0)) begin
                    w_pause_cnt_nx = r_pause_cnt - FRAME_W'(1);
                end
                if (w_pause_cnt_nx == '0) begin
                    w_state_nx = ST_PLAY;
                end
            end
            ST_GAME_OVER: begin
                if (start) begin
                    w_state_nx        = ST_PLAY;
                    w_level_nx        = LEVEL_W'(1);
                    w_level_change_nx = 1'b1;
                    w_lives_nx        = LIVES_RST;
                    w_inv_cnt_nx      = '0;
                end
            end
`ifdef GAME_FLOW_PAUSE_EN
            ST_PAUSED: begin
                if (pause_req) begin
                    w_state_nx = ST_PLAY;
                end
            end
`endif
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            w_alive_nx[i]  = (w_lives_nx[i] != '0);
            w_invuln_nx[i] = (w_inv_cnt_nx[i] != '0);
        end
        w_freeze_nx    = (w_state_nx != ST_PLAY);
        w_game_over_nx = (w_state_nx == ST_GAME_OVER);
`ifdef GAME_FLOW_PAUSE_EN
        w_paused_nx     = (w_state_nx == ST_PAUSED);
        w_state_code_nx = (w_state_nx == ST_PAUSED) ? 2'd0 : w_state_nx[1:0];
`else
        w_state_code_nx = w_state_nx;
`endif
    end

    assign level        = r_level;
    assign level_change = r_level_change;
    assign lives        = r_lives;
    assign alive        = r_alive;
    assign invuln       = r_invuln;
    assign freeze       = r_freeze;
    assign game_over    = r_game_over;
    assign state        = r_state_code;
`ifdef GAME_FLOW_PAUSE_EN
    assign paused       = r_paused;
`endif

endmodule
